// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm -- multicycle MIPS control unit.
//
// A Moore FSM that steps the datapath through FETCH, DECODE and the
// per-class execute/memory/writeback states. It produces the
// write-enables and mux selects for PC, IR, MDR, the register file and
// the memory port. It also counts retired instructions.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   OpCode, Funct   IR[31:26] and IR[5:0], decoded from DECODE onward
//   Zero            ALU zero flag, used by beq/bne
//   mem_ready       the current memory access completes this cycle
//   PCWrite, IRWrite, MemRead, MemWrite, RegWrite   write enables/requests
//   IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ExtOp, PCSource
//                   datapath mux selects and ALU control
//   illegal_op      one-cycle pulse in DECODE for an unknown opcode
//   state_o         current state code
//   retired         retired-instruction count, wraps modulo 2^CNT_W
module mc_ctrl_fsm #(
  parameter int          CNT_W    = 32,
  parameter logic [5:0]  JR_FUNCT = 6'h08
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             ExtOp,
  output logic [1:0]       PCSource,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  state_t           r_state;
  state_t           w_next;
  logic             w_illegal;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  // State register and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next-state logic. The DECODE fan-out also flags unknown opcodes.
  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OpCode)
          OP_RTYPE:                w_next = (Funct == JR_FUNCT) ? S_JR : S_R_EXEC;
          OP_LW, OP_SW:            w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:          w_next = S_BRANCH;
          OP_J, OP_JAL:            w_next = S_JUMP;
          6'h08, 6'h09, 6'h0a, 6'h0b,
          6'h0c, 6'h0d, 6'h0f:     w_next = S_I_EXEC;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: w_next = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = mem_ready ? S_LW_WB : S_MEM_RD;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_LW_WB:    w_next = S_FETCH;
      S_R_EXEC:   w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_I_EXEC:   w_next = S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      S_JR:       w_next = S_FETCH;
      default:    w_next = S_FETCH;
    endcase
  end

  // An instruction retires when one of its final states hands back to
  // FETCH. DECODE's illegal-opcode exit is deliberately not in this set.
  always_comb begin
    w_retire = 1'b0;
    if (w_next == S_FETCH) begin
      case (r_state)
        S_LW_WB, S_MEM_WR, S_R_WB, S_BRANCH,
        S_JUMP, S_I_WB, S_JR: w_retire = 1'b1;
        default:              w_retire = 1'b0;
      endcase
    end
  end

  // Moore outputs per state. Reset is applied combinationally at the end,
  // so FETCH's MemRead does not leak out while reset is held.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    ExtOp      = 1'b0;
    PCSource   = 2'b00;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        ExtOp      = 1'b1;
        illegal_op = w_illegal;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_LW_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 2'b01;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 2'b01;
        PCWrite  = (OpCode == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        // jal links PC+4; the PC register is not overwritten until this edge.
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        // andi/ori/lui use a zero-extended immediate.
        ExtOp   = !(OpCode == 6'h0c || OpCode == 6'h0d || OpCode == 6'h0f);
      end
      S_I_WB: begin
        RegWrite = 1'b1;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IorD       = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      ExtOp      = 1'b0;
      PCSource   = 2'b00;
      illegal_op = 1'b0;
    end
  end

  assign state_o = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm -- self-checking bench for mc_ctrl_fsm.
//
// Each instruction is expanded into the list of cycles it should take,
// using the instruction-class rules (which states it visits, where it
// waits on memory, which enable fires in which cycle). The DUT is then
// stepped through that list and compared cycle by cycle. A small
// counter width makes the retired-count wrap reachable.
module tb_mc_ctrl_fsm;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [5:0]    OpCode;
  logic [5:0]    Funct;
  logic          Zero;
  logic          mem_ready;
  logic          PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite;
  logic [1:0]    RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource;
  logic          ALUSrcA, ExtOp, illegal_op;
  logic [3:0]    state_o;
  logic [CW-1:0] retired;

  int total;
  int bad;
  int modelRet;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic       mr, mw, rw, pw, iw, ill;
    logic [1:0] pcs, m2r, rdst;
    logic       ext;
  } step_t;

  mc_ctrl_fsm #(.CNT_W(CW), .JR_FUNCT(6'h08)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ExtOp(ExtOp), .PCSource(PCSource), .illegal_op(illegal_op),
    .state_o(state_o), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isLegal(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
      6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // A quiet cycle in state st; mem_ready is random where it must not matter.
  function automatic step_t blank(input logic [3:0] st);
    step_t s;
    s = '{st: st, rdy: 1'($urandom_range(0, 1)), mr: 0, mw: 0, rw: 0, pw: 0,
          iw: 0, ill: 0, pcs: 2'b00, m2r: 2'b00, rdst: 2'b00, ext: 0};
    return s;
  endfunction

  // Runs one instruction from FETCH back to FETCH. wf/wm are the number of
  // not-ready cycles in the fetch and the data-memory access.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    step_t q[$];
    step_t s;
    bit    legal;
    legal = isLegal(op);
    for (int i = 0; i <= wf; i++) begin
      s = blank(4'd0);
      s.rdy = (i == wf);
      s.mr = 1'b1;
      s.iw = s.rdy;
      s.pw = s.rdy;
      q.push_back(s);
    end
    s = blank(4'd1);
    s.ext = 1'b1;
    s.ill = !legal;
    q.push_back(s);
    if (legal) begin
      if (op == 6'h00 && fn == 6'h08) begin
        s = blank(4'd12); s.pw = 1'b1; s.pcs = 2'b11; q.push_back(s);
      end else if (op == 6'h00) begin
        q.push_back(blank(4'd6));
        s = blank(4'd7); s.rw = 1'b1; s.rdst = 2'b01; q.push_back(s);
      end else if (op == 6'h23 || op == 6'h2b) begin
        s = blank(4'd2); s.ext = 1'b1; q.push_back(s);
        for (int i = 0; i <= wm; i++) begin
          s = blank((op == 6'h23) ? 4'd3 : 4'd5);
          s.rdy = (i == wm);
          s.mr = (op == 6'h23);
          s.mw = (op == 6'h2b);
          q.push_back(s);
        end
        if (op == 6'h23) begin
          s = blank(4'd4); s.rw = 1'b1; s.m2r = 2'b01; q.push_back(s);
        end
      end else if (op == 6'h04 || op == 6'h05) begin
        s = blank(4'd8); s.pcs = 2'b01;
        s.pw = (op == 6'h04) ? z : !z;
        q.push_back(s);
      end else if (op == 6'h02 || op == 6'h03) begin
        s = blank(4'd9); s.pw = 1'b1; s.pcs = 2'b10;
        if (op == 6'h03) begin
          s.rw = 1'b1; s.rdst = 2'b10; s.m2r = 2'b10;
        end
        q.push_back(s);
      end else begin
        s = blank(4'd10);
        s.ext = !(op == 6'h0c || op == 6'h0d || op == 6'h0f);
        q.push_back(s);
        s = blank(4'd11); s.rw = 1'b1; q.push_back(s);
      end
    end
    OpCode = op;
    Funct  = fn;
    Zero   = z;
    foreach (q[k]) begin
      @(negedge clk);
      mem_ready = q[k].rdy;
      #1;
      total++;
      if (state_o !== q[k].st) begin
        bad++;
        $display("[TB] FAIL state op=%h cyc=%0d got=%0d want=%0d", op, k, state_o, q[k].st);
      end
      total++;
      if ({MemRead, MemWrite, RegWrite, PCWrite, IRWrite, illegal_op} !==
          {q[k].mr, q[k].mw, q[k].rw, q[k].pw, q[k].iw, q[k].ill}) begin
        bad++;
        $display("[TB] FAIL enables op=%h st=%0d got=%b want=%b", op, q[k].st,
                 {MemRead, MemWrite, RegWrite, PCWrite, IRWrite, illegal_op},
                 {q[k].mr, q[k].mw, q[k].rw, q[k].pw, q[k].iw, q[k].ill});
      end
      total++;
      if ({PCSource, MemtoReg, RegDst, ExtOp} !== {q[k].pcs, q[k].m2r, q[k].rdst, q[k].ext}) begin
        bad++;
        $display("[TB] FAIL selects op=%h st=%0d got=%b want=%b", op, q[k].st,
                 {PCSource, MemtoReg, RegDst, ExtOp}, {q[k].pcs, q[k].m2r, q[k].rdst, q[k].ext});
      end
      @(posedge clk);
    end
    if (legal) modelRet = (modelRet + 1) % (1 << CW);
    #1;
    total++;
    if (state_o !== 4'd0 || retired !== CW'(modelRet)) begin
      bad++;
      $display("[TB] FAIL retire op=%h state=%0d retired=%0d want state=0 retired=%0d",
               op, state_o, retired, modelRet);
    end
  endtask

  // Reset while a load is stalled in MEM_RD must clear everything at once.
  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; OpCode = 6'h23; Funct = 6'h00; Zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelRet = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if (state_o !== 4'd3 || MemRead !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reach_memrd got state=%0d MemRead=%b want 3/1", state_o, MemRead);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({MemRead, IorD, PCWrite, IRWrite, state_o, retired} !== {4'b0000, 4'd0, CW'(0)}) begin
      bad++;
      $display("[TB] FAIL reset_now got MemRead=%b IorD=%b state=%0d retired=%0d want all 0",
               MemRead, IorD, state_o, retired);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({MemRead, IorD, ALUSrcB, PCWrite, IRWrite, state_o} !== {1'b1, 1'b0, 2'b01, 2'b00, 4'd0}) begin
      bad++;
      $display("[TB] FAIL after_reset got MemRead=%b IorD=%b ALUSrcB=%b state=%0d want 1/0/01/0",
               MemRead, IorD, ALUSrcB, state_o);
    end
    @(posedge clk);
  endtask

  task automatic test_lw;
    run_instr(6'h23, 6'h00, 1'b0, 0, 0);
    run_instr(6'h23, 6'h15, 1'b1, 2, 1);
  endtask

  task automatic test_sw_wait;
    run_instr(6'h2b, 6'h00, 1'b0, 0, 3);
  endtask

  task automatic test_branch;
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);
    run_instr(6'h04, 6'h00, 1'b0, 1, 0);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_jumps;
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    run_instr(6'h0c, 6'h00, 1'b0, 0, 0);
    run_instr(6'h08, 6'h00, 1'b0, 0, 0);
  endtask

  task automatic test_illegal;
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0);
    run_instr(6'h01, 6'h08, 1'b0, 1, 0);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < (1 << CW) && modelRet != (1 << CW) - 1; i++) begin
      run_instr(6'h02, 6'h00, 1'b0, 0, 0);
    end
    run_instr(6'h0d, 6'h00, 1'b0, 0, 0);
    total++;
    if (retired !== CW'(0)) begin
      bad++;
      $display("[TB] FAIL wrap got retired=%0d want 0", retired);
    end
  endtask

  // Random mix of legal and illegal opcodes with random memory stalls.
  task automatic test_back_to_back;
    logic [5:0] ops[18];
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
            6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h3f, 6'h0e, 6'h20};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = ops[$urandom_range(0, 17)];
      fn = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom);
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    modelRet = 0;
    test_reset;
    test_lw;
    test_sw_wait;
    test_branch;
    test_jumps;
    test_illegal;
    test_wrap;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS control unit that sequences the write-enabled datapath registers: PC, IR, MDR, register file and memory port.
- Moore FSM decodes OpCode/Funct from the latched IR.
- Drives one-hot-in-time write enables plus mux selects.
- Handles a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- JR_FUNCT, 6'h08, Funct code decoded as jr

Ports:
- clk  in  1  clock
- reset  in  1  reset
- OpCode  in  6  IR[31:26], valid from DECODE until next FETCH
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable (branch condition already folded in)
- IRWrite  out  1  IR enable
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  0=PC address, 1=ALUOut address
- RegWrite  out  1  register file write
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
- ALUSrcA  out  1  0 PC, 1 rs
- ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 by Funct, 11 by OpCode
- ExtOp  out  1  1 sign-extend, 0 zero-extend
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
- illegal_op  out  1  one-cycle pulse in DECODE on unknown opcode
- state_o  out  4  current state code
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: asynchronous, active-high, clock clk.
  - While reset is high: state=FETCH (0), retired=0, every output forced 0, including write enables and MemRead.
- Outputs are combinational from state, gated by mem_ready and Zero where noted. Unlisted outputs are 0.
- State codes:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7
  - BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JR=12
  - Codes 13-15 go to FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Holds in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcB=11, ExtOp=1 (branch target into ALUOut). Next state by OpCode:
  - 00: JR if Funct==JR_FUNCT, else R_EXEC
  - 23, 2b: MEM_ADDR
  - 04, 05: BRANCH
  - 02, 03: JUMP
  - 08, 09, 0a, 0b, 0c, 0d, 0f: I_EXEC
  - anything else: illegal_op=1, go to FETCH
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=1. Goes to MEM_RD for lw (23), MEM_WR for sw (2b).
- MEM_RD: MemRead=1, IorD=1. Holds until mem_ready=1, then LW_WB.
- MEM_WR: MemWrite=1, IorD=1. Holds until mem_ready=1, then FETCH.
- LW_WB: RegWrite=1, RegDst=00, MemtoReg=01. Goes to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
- R_WB: RegWrite=1, RegDst=01, MemtoReg=00. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PCWrite=Zero for beq, ~Zero for bne. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10.
  - For jal (03) also RegWrite=1, RegDst=10, MemtoReg=10. PC still holds PC+4 this cycle.
  - Goes to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. ExtOp=0 for 0c, 0d, 0f; 1 otherwise. Goes to I_WB.
- I_WB: RegWrite=1, RegDst=00, MemtoReg=00. Goes to FETCH.
- JR: PCWrite=1, PCSource=11. Goes to FETCH.
- Cycle counts with mem_ready tied 1:
  - lw 5; sw, R-type, I-type 4; beq/bne, j/jal, jr 3.
  - Each mem_ready=0 cycle adds 1.
- retired: increments by 1 (wrapping modulo 2^CNT_W) on every transition into FETCH from LW_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB or JR. Never increments on the illegal-opcode path.
- Reset mid-instruction: state goes to FETCH immediately, enables drop to 0 in the same cycle, retired clears.

Test Plan:
- Reset asserted in MEM_RD with mem_ready=0 -> same cycle MemRead=0, state_o=0, retired=0. After release, FETCH outputs present.
- lw (OpCode 23), mem_ready=1 -> state_o 0,1,2,3,4,0. RegWrite=1 with MemtoReg=01 only in state 4. retired increments 0->1 on entering 0.
- sw, mem_ready low 3 cycles in MEM_WR -> MemWrite=1 held 4 cycles, state holds 5, retired increments once.
- beq in BRANCH with Zero=1 -> PCWrite=1, PCSource=01. bne with Zero=1 -> PCWrite=0.
- jal (03) -> JUMP: PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10. R-type Funct 08 -> JR: PCSource=11, no RegWrite.
- OpCode 3f -> illegal_op=1 for exactly one cycle in DECODE, then FETCH, retired unchanged. Also preload retired near all-ones and retire 1 instruction -> wraps to 0.
